// File: rtl/tetris_piece_mover.sv
// Falling-piece position tracker and mirrored sprite-ROM address generator.
// Owns one tetromino: spawn, frame-paced fall, left/right moves, landing pulse.
module tetris_piece_mover #(
  parameter int SIZE      = 20,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_START   = 0,
  parameter int Y_FLOOR   = 460,
  parameter int FALL_DIV  = 4,
  parameter int FALL_STEP = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic       move_left,
  input  logic       move_right,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       busy,
  output logic       landed,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       sprite_on,
  output logic [9:0] SpriteX,
  output logic [9:0] SpriteY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FALL = 2'd1;
  localparam logic [1:0] S_LAND = 2'd2;

  localparam int CNT_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_DIV - 1);

  localparam logic [10:0] SIZE11 = 11'(SIZE);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XLIM11 = 11'(X_MAX - SIZE + 1);
  localparam logic [10:0] YFLR11 = 11'(Y_FLOOR);
  localparam logic [10:0] STEP11 = 11'(FALL_STEP);

  logic [1:0]       state_q, state_d;
  logic [9:0]       posx_q, posx_d;
  logic [9:0]       posy_q, posy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vis_q, vis_d;
  logic             frame_d_q;
  logic             tick;

  logic             sprite_on_q;
  logic [9:0]       spx_q, spy_q;
  logic [10:0]      dx, dy, px, py, offx, offy;
  logic             inbox;

  function automatic logic [9:0] clamp_x(input logic [10:0] x);
    if (x < XMIN11)      return XMIN11[9:0];
    else if (x > XLIM11) return XLIM11[9:0];
    else                 return x[9:0];
  endfunction

  // Left step floors at X_MIN without ever going below zero in 11 bits.
  function automatic logic [9:0] step_left(input logic [9:0] p);
    logic [10:0] p11;
    p11 = {1'b0, p};
    if (p11 < XMIN11 + SIZE11) return XMIN11[9:0];
    else                       return 10'(p11 - SIZE11);
  endfunction

  function automatic logic [9:0] fall_y(input logic [9:0] p);
    logic [10:0] s;
    s = {1'b0, p} + STEP11;
    return (s > YFLR11) ? YFLR11[9:0] : s[9:0];
  endfunction

  assign tick = frame_clk & ~frame_d_q;

  always_comb begin
    state_d = state_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    cnt_d   = cnt_q;
    vis_d   = vis_q;
    case (state_q)
      S_IDLE: begin
        if (spawn) begin
          posx_d  = clamp_x({1'b0, spawn_x});
          posy_d  = 10'(Y_START);
          cnt_d   = '0;
          vis_d   = 1'b1;
          state_d = S_FALL;
        end
      end
      S_FALL: begin
        if (tick) begin
          if (move_left & ~move_right)      posx_d = step_left(posx_q);
          else if (move_right & ~move_left) posx_d = clamp_x({1'b0, posx_q} + SIZE11);
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            posy_d = fall_y(posy_q);
            if ({1'b0, posy_d} == YFLR11) state_d = S_LAND;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LAND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      posx_q    <= XMIN11[9:0];
      posy_q    <= 10'(Y_START);
      cnt_q     <= '0;
      vis_q     <= 1'b0;
      frame_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      posx_q    <= posx_d;
      posy_q    <= posy_d;
      cnt_q     <= cnt_d;
      vis_q     <= vis_d;
      frame_d_q <= frame_clk;
    end
  end

  // Draw stage: 11-bit compares so PosX+SIZE near the screen edge cannot wrap.
  assign dx    = {1'b0, DrawX};
  assign dy    = {1'b0, DrawY};
  assign px    = {1'b0, posx_q};
  assign py    = {1'b0, posy_q};
  assign offx  = dx - px;
  assign offy  = dy - py;
  assign inbox = vis_q & (dx >= px) & (dx < px + SIZE11) & (dy >= py) & (dy < py + SIZE11);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sprite_on_q <= 1'b0;
      spx_q       <= '0;
      spy_q       <= '0;
    end else begin
      sprite_on_q <= inbox;
      spx_q       <= inbox ? 10'(SIZE11 - 11'd1 - offx) : '0;
      spy_q       <= inbox ? 10'(SIZE11 - 11'd1 - offy) : '0;
    end
  end

  assign busy      = (state_q == S_FALL);
  assign landed    = (state_q == S_LAND);
  assign PosX      = posx_q;
  assign PosY      = posy_q;
  assign sprite_on = sprite_on_q;
  assign SpriteX   = spx_q;
  assign SpriteY   = spy_q;

endmodule

// File: doc/tetris_piece_mover.md
# tetris_piece_mover

Sequential position and draw-address stage that sits directly upstream of the palette sprite ROMs (20x20 tetromino cell sprites) in the color-mapper path. It owns one falling piece: it accepts a spawn request, steps the piece down on frame edges, applies left/right moves, and signals landing. Every pixel clock it converts the current DrawX/DrawY into the mirrored SpriteX/SpriteY the sprite ROM expects, plus a sprite_on qualifier, all registered.

## Interface
- SIZE, 20: sprite width and height in pixels.
- X_MIN, 0: leftmost legal PosX.
- X_MAX, 639: rightmost screen pixel; PosX never exceeds X_MAX-SIZE+1.
- Y_START, 0: PosY loaded on spawn.
- Y_FLOOR, 460: PosY at which the piece lands.
- FALL_DIV, 4: frame edges per fall step (>=1).
- FALL_STEP, 4: pixels per fall step.

- Clk  in  1  pixel/system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  frame strobe (vsync), synchronous to Clk; rising edge = frame tick.
- spawn  in  1  spawn request, sampled every cycle.
- spawn_x  in  10  requested PosX for spawn.
- move_left, move_right  in  1  sampled at frame ticks.
- DrawX, DrawY  in  10  current pixel coordinate.
- busy  out  1  piece is falling.
- landed  out  1  one-cycle pulse when the piece reaches Y_FLOOR.
- PosX, PosY  out  10  current top-left position.
- sprite_on  out  1  registered: DrawX/DrawY inside the visible piece.
- SpriteX, SpriteY  out  10  registered ROM address.

## Operation
- States: IDLE, FALLING, LANDED.
- Frame tick: frame_clk & ~frame_clk_d, where frame_clk_d is a 1-cycle delayed register.
- IDLE: spawn=1 is accepted. PosX <= clamp(spawn_x, X_MIN, X_MAX-SIZE+1). PosY <= Y_START. fall_cnt <= 0. visible <= 1. Next state is FALLING.
- FALLING, on each frame tick:
  - Horizontal move first. move_left alone: PosX -= SIZE, floored at X_MIN. move_right alone: PosX += SIZE, capped at X_MAX-SIZE+1. Both or neither: no move.
  - Then fall_cnt increments. At FALL_DIV-1, fall_cnt <= 0 and PosY <= min(PosY+FALL_STEP, Y_FLOOR), computed in 11 bits.
  - If the new PosY equals Y_FLOOR, the next state is LANDED.
- LANDED: lasts exactly 1 cycle, landed=1, then IDLE. The piece stays visible at its final position until the next spawn.
- spawn while FALLING or LANDED is ignored; no queuing.
- spawn and frame tick in the same IDLE cycle: spawn wins, and that tick is not counted.
- Y_START >= Y_FLOOR: the first fall step lands the piece.
- busy = (state == FALLING).
- Draw path, with all compares in 11 bits to avoid wrap:
  - inbox = visible & DrawX>=PosX & DrawX<PosX+SIZE & DrawY>=PosY & DrawY<PosY+SIZE.
  - inbox=1: SpriteX <= SIZE-1-(DrawX-PosX) and SpriteY <= SIZE-1-(DrawY-PosY). Range is 19..0, mirrored as the ROM requires.
  - inbox=0: SpriteX, SpriteY <= 0.
  - sprite_on <= inbox.

## Timing
- Reset values:
  - state=IDLE, busy=0, landed=0, visible=0, PosX=X_MIN, PosY=Y_START, fall_cnt=0, frame_clk_d=0.
  - sprite_on=0, SpriteX=0, SpriteY=0.
- Draw path latency: 1 Clk. Outputs for DrawX/DrawY sampled at edge n appear after edge n.
- Position updates take effect in the draw path on the cycle after they register.
- Spawn to busy=1: 1 cycle.
- Final fall step: LANDED is entered on the edge after the tick. landed=1 for that one cycle, and busy=0 in the same cycle.
- Reset asserted mid-fall: immediate return to reset values. No landed pulse is generated.

## Test plan
- Reset: assert Reset mid-FALLING -> next sample busy=0, landed=0, sprite_on=0, PosY=Y_START.
- Fall: spawn with spawn_x=100 -> busy=1 next cycle. After 4 ticks PosY=4; after 8 ticks PosY=8; PosX stays 100.
- Draw: PosX=100, PosY=40.
  - DrawX=100, DrawY=40 -> next cycle sprite_on=1, SpriteX=19, SpriteY=19.
  - DrawX=119, DrawY=59 -> next cycle SpriteX=0, SpriteY=0.
  - DrawX=120 -> next cycle sprite_on=0, SpriteX=0.
- Land: Y_START=452, FALL_DIV=1 -> tick 1 gives PosY=456; tick 2 gives PosY=460 and a single-cycle landed pulse, then busy=0. Piece is still drawn at PosY=460.
- Clamp and handshake:
  - spawn_x=630 -> PosX=620.
  - move_right at 620 -> stays 620.
  - move_left and move_right together -> no change.
  - spawn while busy -> ignored; PosY continues uninterrupted.
- Collision: spawn and frame tick in the same cycle -> fall_cnt=0 after spawn; the first step occurs exactly FALL_DIV subsequent ticks later.
